// File: rtl/acc_sequencer_if.sv
// Control/status bundle for acc_sequencer: run configuration and handshakes in,
// accumulation boundary pulse and run status out.
interface acc_sequencer_if #(
   parameter int LEN_WIDTH = 32,
   parameter int CNT_WIDTH = 16
);
   logic                 ce;
   logic                 sync_in;
   logic [LEN_WIDTH-1:0] acc_len;
   logic [CNT_WIDTH-1:0] num_acc;
   logic                 arm;
   logic                 abort;
   logic                 new_acc;
   logic                 busy;
   logic                 done;
   logic [CNT_WIDTH-1:0] acc_cnt;

   modport master (
      output ce, sync_in, acc_len, num_acc, arm, abort,
      input  new_acc, busy, done, acc_cnt
   );

   modport slave (
      input  ce, sync_in, acc_len, num_acc, arm, abort,
      output new_acc, busy, done, acc_cnt
   );
endinterface

// File: rtl/acc_sequencer.sv
// Accumulation sequencer: counts spectra frames after a sync and pulses new_acc at
// each accumulation boundary. Define ACC_SEQ_RESYNC_EN to let sync_in restart frames in RUN.
module acc_sequencer #(
   parameter int CHANNEL_ADDR = 7,
   parameter int LEN_WIDTH    = 32,
   parameter int CNT_WIDTH    = 16
) (
   input logic            clk,
   input logic            rst,
   acc_sequencer_if.slave bus
);
   localparam int FW = LEN_WIDTH + CHANNEL_ADDR;

   typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN, DONE} state_t;

   state_t               state, state_nxt;
   logic [FW-1:0]        frame_cnt;
   logic [FW-1:0]        frame_len;
   logic [LEN_WIDTH-1:0] len_shadow;
   logic [LEN_WIDTH-1:0] len_eff;
   logic [CNT_WIDTH-1:0] num_shadow;
   logic [CNT_WIDTH-1:0] acc_cnt;
   logic                 tick;
   logic                 boundary;
   logic                 last_acc;
   logic                 resync;

   // Frame length is widened before the shift so large acc_len never truncates.
   assign len_eff   = (len_shadow == '0) ? LEN_WIDTH'(1) : len_shadow;
   assign frame_len = FW'(len_eff) << CHANNEL_ADDR;

   // abort suppresses every RUN action, including the boundary pulse.
   assign tick     = (state == RUN) && bus.ce && !bus.abort;
   assign boundary = tick && (frame_cnt == frame_len);
   assign last_acc = (num_shadow != '0) && ((acc_cnt + CNT_WIDTH'(1)) == num_shadow);

`ifdef ACC_SEQ_RESYNC_EN
   assign resync = tick && bus.sync_in;
`else
   assign resync = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      if (bus.abort) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE, DONE: if (bus.arm) state_nxt = WAIT_SYNC;
            WAIT_SYNC:  if (bus.ce && bus.sync_in) state_nxt = RUN;
            RUN:        if (boundary && last_acc) state_nxt = DONE;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.new_acc = boundary;
      bus.busy    = (state == WAIT_SYNC) || (state == RUN);
      bus.done    = (state == DONE);
      bus.acc_cnt = acc_cnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt  <= '0;
         len_shadow <= '0;
         num_shadow <= '0;
         acc_cnt    <= '0;
      end else if (!bus.abort) begin
         unique case (state)
            IDLE, DONE: begin
               if (bus.arm) acc_cnt <= '0;
            end
            WAIT_SYNC: begin
               if (bus.ce && bus.sync_in) begin
                  len_shadow <= bus.acc_len;
                  num_shadow <= bus.num_acc;
                  frame_cnt  <= FW'(1);
               end
            end
            RUN: begin
               // acc_len is picked up only here, so mid-frame edits wait for the boundary.
               if (boundary) begin
                  frame_cnt  <= FW'(1);
                  acc_cnt    <= acc_cnt + CNT_WIDTH'(1);
                  len_shadow <= bus.acc_len;
               end else if (resync) begin
                  frame_cnt <= FW'(1);
               end else if (bus.ce) begin
                  frame_cnt <= frame_cnt + FW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer at CHANNEL_ADDR=2; resync expectations follow
// whether ACC_SEQ_RESYNC_EN is defined.
module tb_acc_sequencer;
   localparam int CA = 2;
   localparam int LW = 32;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   acc_sequencer_if #(.LEN_WIDTH(LW), .CNT_WIDTH(CW)) bus ();

   acc_sequencer #(.CHANNEL_ADDR(CA), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, settle, then outputs are sampled.
   task automatic cycle(input logic ce, input logic sync, input logic arm, input logic abort);
      @(negedge clk);
      bus.ce      = ce;
      bus.sync_in = sync;
      bus.arm     = arm;
      bus.abort   = abort;
      #1;
   endtask

   task automatic start_run(input int len, input int num);
      bus.acc_len = LW'(len);
      bus.num_acc = CW'(num);
      cycle(1, 0, 1, 0);
      cycle(1, 1, 0, 0);
   endtask

   initial begin
      int c;
      int pulses;
      int resync_pos;
      bus.ce = 0; bus.sync_in = 0; bus.arm = 0; bus.abort = 0;
      bus.acc_len = '0; bus.num_acc = '0;
      #12;
      check("rst_new_acc", 32'(bus.new_acc), 0);
      check("rst_busy",    32'(bus.busy), 0);
      check("rst_done",    32'(bus.done), 0);
      check("rst_acc_cnt", 32'(bus.acc_cnt), 0);
      @(negedge clk);
      rst = 0;

      // Fixed run: L=12, two accumulations, then DONE.
      start_run(3, 2);
      check("t1_busy_after_sync", 32'(bus.busy), 1);
      for (int k = 1; k <= 26; k++) begin
         cycle(1, 0, 0, 0);
         check($sformatf("t1_new_acc_k%0d", k), 32'(bus.new_acc), 32'((k == 12) || (k == 24)));
         check($sformatf("t1_done_k%0d", k), 32'(bus.done), 32'(k >= 25));
      end
      check("t1_acc_cnt", 32'(bus.acc_cnt), 2);
      check("t1_busy_done", 32'(bus.busy), 0);
      cycle(1, 0, 0, 0);
      check("t1_acc_cnt_hold", 32'(bus.acc_cnt), 2);
      cycle(1, 0, 1, 0);
      cycle(1, 0, 0, 0);
      check("t1_rearm_clears", 32'(bus.acc_cnt), 0);
      check("t1_rearm_busy", 32'(bus.busy), 1);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 0);
      check("t1_abort_idle", 32'(bus.busy), 0);

      // Continuous, acc_len=0 -> L=4, ce toggling.
      start_run(0, 0);
      c = 0;
      pulses = 0;
      for (int k = 1; k <= 40; k++) begin
         logic ce_k;
         logic exp_pulse;
         ce_k = logic'(k % 2);
         cycle(ce_k, 0, 0, 0);
         exp_pulse = 1'b0;
         if (ce_k) begin
            c++;
            exp_pulse = (c % 4 == 0);
         end
         check($sformatf("t2_new_acc_k%0d", k), 32'(bus.new_acc), 32'(exp_pulse));
         check($sformatf("t2_done_k%0d", k), 32'(bus.done), 0);
         if (exp_pulse) pulses++;
      end
      check("t2_acc_cnt", 32'(bus.acc_cnt), 32'(pulses));
      cycle(1, 0, 0, 1);
      check("t2_abort_no_pulse", 32'(bus.new_acc), 0);

      // acc_len 3 -> 5 mid-frame; num_acc edit and arm in RUN must be ignored.
      start_run(3, 0);
      for (int k = 1; k <= 33; k++) begin
         if (k == 5) begin
            bus.acc_len = LW'(5);
            bus.num_acc = CW'(1);
         end
         cycle(1, 0, (k == 20), 0);
         check($sformatf("t3_new_acc_k%0d", k), 32'(bus.new_acc), 32'((k == 12) || (k == 32)));
      end
      check("t3_acc_cnt", 32'(bus.acc_cnt), 2);
      check("t3_busy", 32'(bus.busy), 1);
      cycle(1, 0, 0, 1);

      // abort coincident with the boundary.
      start_run(3, 0);
      for (int k = 1; k <= 11; k++) cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 1);
      check("t4_abort_new_acc", 32'(bus.new_acc), 0);
      cycle(1, 0, 0, 0);
      check("t4_busy", 32'(bus.busy), 0);
      check("t4_done", 32'(bus.done), 0);
      check("t4_acc_cnt", 32'(bus.acc_cnt), 0);

      // Asynchronous reset while new_acc is high.
      start_run(1, 0);
      for (int k = 1; k <= 12; k++) cycle(1, 0, 0, 0);
      check("t5_pre_new_acc", 32'(bus.new_acc), 1);
      check("t5_pre_acc_cnt", 32'(bus.acc_cnt), 2);
      #1 rst = 1;
      #1;
      check("t5_rst_new_acc", 32'(bus.new_acc), 0);
      check("t5_rst_busy",    32'(bus.busy), 0);
      check("t5_rst_done",    32'(bus.done), 0);
      check("t5_rst_acc_cnt", 32'(bus.acc_cnt), 0);
      @(negedge clk);
      rst = 0;
      cycle(1, 1, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         cycle(1, 0, 0, 0);
         check($sformatf("t5_idle_busy_k%0d", k), 32'(bus.busy), 0);
         check($sformatf("t5_idle_new_acc_k%0d", k), 32'(bus.new_acc), 0);
      end

      // sync at counter=7 with L=12.
`ifdef ACC_SEQ_RESYNC_EN
      resync_pos = 19;
`else
      resync_pos = 12;
`endif
      start_run(3, 0);
      for (int k = 1; k <= 20; k++) begin
         cycle(1, (k == 7), 0, 0);
         check($sformatf("t6_new_acc_k%0d", k), 32'(bus.new_acc), 32'(k == resync_pos));
      end
      check("t6_acc_cnt", 32'(bus.acc_cnt), 1);
      cycle(1, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
